uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter CLK_PER_BIT, 868, clocks per UART bit; used only for the timeout.
REQ-002 Parameter ADDR_W, 4, register address width; the register space is 2**ADDR_W bytes.
REQ-003 Parameter TIMEOUT_BITS, 20, inter-byte timeout in bit times.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-high, rst.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rx_byte_valid  in  1  one-cycle strobe: received byte is valid.
REQ-008 rx_byte_data  in  8  received byte.
REQ-009 par_error  in  1  parity error on the current received byte, sampled with rx_byte_valid.
REQ-010 stop_error  in  1  stop-bit error on the current received byte, sampled with rx_byte_valid.
REQ-011 tx_byte_valid  out  1  request to transmit tx_byte_data.
REQ-012 tx_byte_data  out  8  byte to transmit.
REQ-013 tx_active  in  1  the transmitter has accepted the byte and is sending.
REQ-014 tx_done  in  1  one-cycle strobe: transmission is complete.
REQ-015 reg_addr  out  ADDR_W  register bus address.
REQ-016 reg_wr_en  out  1  one-cycle register write strobe.
REQ-017 reg_wr_data  out  8  register write data.
REQ-018 reg_rd_data  in  8  register read data, valid the cycle after reg_addr is stable.
REQ-019 busy  out  1  high in every state other than IDLE.
REQ-020 overrun  out  1  sticky: a byte arrived while the block was transmitting.

Function
REQ-021 The FSM SHALL have the states IDLE, GET_ADDR, GET_DATA, RD_WAIT, TX_REQ and TX_WAIT.
REQ-022 In IDLE, receiving 0x57 ('W') SHALL go to GET_ADDR with op=write; 0x52 ('R') SHALL go to GET_ADDR with op=read; any other byte SHALL load response 0x45 ('E') and go to TX_REQ.
REQ-023 In GET_ADDR, a received byte with a value of 2**ADDR_W or more SHALL produce response 'E'; otherwise it is latched into reg_addr, and the FSM goes to GET_DATA (write) or RD_WAIT (read).
REQ-024 In GET_DATA, a received byte SHALL drive reg_wr_data, pulse reg_wr_en for exactly one cycle, load response 0x4B ('K') and go to TX_REQ.
REQ-025 RD_WAIT SHALL last exactly one cycle; it then captures reg_rd_data as the response and goes to TX_REQ.
REQ-026 In TX_REQ, tx_byte_valid SHALL be held high until tx_active is seen; it drops in the same cycle the FSM enters TX_WAIT.
REQ-027 TX_WAIT SHALL return to IDLE on tx_done.
REQ-028 Any received byte with par_error or stop_error in IDLE, GET_ADDR or GET_DATA SHALL abort the frame with no register access and respond 'E'.
REQ-029 A byte received in TX_REQ or TX_WAIT SHALL be dropped and SHALL set overrun.
REQ-030 Latency: the first tx_byte_valid SHALL occur 1 cycle after the final rx_byte_valid of a write or error frame, and 2 cycles after it for a read.
REQ-031 There SHALL be exactly one response byte per frame; a frame is never both written and errored.

Reset
REQ-032 On rst: state=IDLE; tx_byte_valid=0, tx_byte_data=0x00, reg_addr=0, reg_wr_en=0, reg_wr_data=0x00, busy=0, overrun=0; the timeout counter clears.
REQ-033 rst mid-frame or mid-transmit SHALL discard the frame with no reg_wr_en pulse and no further tx_byte_valid.

Configuration
REQ-034 With UART_CMD_TIMEOUT_EN defined, the counter runs in GET_ADDR and GET_DATA, resets on each rx_byte_valid, and at TIMEOUT_BITS*CLK_PER_BIT clocks the FSM returns silently to IDLE with no response.
REQ-035 Without UART_CMD_TIMEOUT_EN, no counter is built and a partial frame waits indefinitely.

Structure
REQ-036 A shared package uart_cmd_pkg SHALL hold the state enum and the byte constants CMD_WR=0x57, CMD_RD=0x52, RSP_ACK=0x4B and RSP_ERR=0x45.
REQ-037 The timeout counter SHALL be one sub-module, uart_cmd_timeout; the FSM and datapath stay in the top module.

Verification (CLK_PER_BIT=10, TIMEOUT_BITS=20, loopback through uart_tx_rx with a host-side model)
REQ-038 Write: send 'W',0x03,0xA5 -> one reg_wr_en pulse with addr 3, data 0xA5; response 0x4B.
REQ-039 Read: preload reg 3=0xA5, send 'R',0x03 -> response 0xA5, no reg_wr_en pulse.
REQ-040 Errors: send 0x00 -> response 0x45; send 'R',0x10 -> response 0x45; send 'W',0x02 with the 3rd byte carrying a forced parity error -> response 0x45 and no write.
REQ-041 Overrun: inject a byte during TX_WAIT -> overrun=1, the response is unchanged, and the next frame still works.
REQ-042 Timeout (macro defined): send 'W', then idle for 200 clocks -> IDLE, no tx_byte_valid; with the macro undefined, the FSM stays in GET_ADDR.
REQ-043 Reset: assert rst during GET_DATA and during TX_WAIT -> all outputs match REQ-032 on the next cycle, with no write.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command responder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        RD_WAIT,
        TX_REQ,
        TX_WAIT
    } state_t;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // True when the received byte addresses a register inside 2**aw bytes.
    function automatic logic addr_ok(input logic [7:0] b, input int unsigned aw);
        return (b >> aw) == 8'd0;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream, transmit handshake and register bus seen by the command responder.
interface uart_cmd_responder_if #(
    parameter int ADDR_W = 4
);
    logic              rx_byte_valid;
    logic [7:0]        rx_byte_data;
    logic              par_error;
    logic              stop_error;
    logic              tx_byte_valid;
    logic [7:0]        tx_byte_data;
    logic              tx_active;
    logic              tx_done;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [7:0]        reg_wr_data;
    logic [7:0]        reg_rd_data;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_byte_valid, rx_byte_data, par_error, stop_error,
        input  tx_active, tx_done, reg_rd_data,
        output tx_byte_valid, tx_byte_data, reg_addr, reg_wr_en, reg_wr_data,
        output busy, overrun
    );

    modport slave (
        output rx_byte_valid, rx_byte_data, par_error, stop_error,
        output tx_active, tx_done, reg_rd_data,
        input  tx_byte_valid, tx_byte_data, reg_addr, reg_wr_en, reg_wr_data,
        input  busy, overrun
    );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter; when EN is 0 nothing is built and expired stays low.
module uart_cmd_timeout #(
    parameter bit          EN    = 1'b1,
    parameter int unsigned LIMIT = 17360
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    generate
        if (EN) begin : g_cnt
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || !run || clear) cnt <= '0;
                else                      cnt <= cnt + 1'b1;
            end

            // A byte in the same cycle wins over expiry.
            assign expired = run && !clear && (cnt == CW'(LIMIT - 1));
        end else begin : g_none
            logic unused_tie;
            assign unused_tie = ^{clk, rst, run, clear};
            assign expired    = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder: 'W' addr data -> write + 'K'; 'R' addr -> read data; else 'E'.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int CLK_PER_BIT  = 868,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input logic clk,
    input logic rst,
    uart_cmd_responder_if.master bus
);
`ifdef UART_CMD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [7:0]        rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              overrun_q, overrun_d;
    logic              in_frame;
    logic              timeout;
    logic              rx_bad;

    assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);
    assign rx_bad   = bus.par_error || bus.stop_error;

    uart_cmd_timeout #(
        .EN    (TIMEOUT_EN),
        .LIMIT (CLK_PER_BIT * TIMEOUT_BITS)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (in_frame),
        .clear   (bus.rx_byte_valid),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_WR;
            rsp_q     <= 8'h00;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rsp_q     <= rsp_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rsp_d     = rsp_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_byte_valid) begin
                    if (rx_bad || (bus.rx_byte_data != CMD_WR && bus.rx_byte_data != CMD_RD)) begin
                        rsp_d   = RSP_ERR;
                        state_d = TX_REQ;
                    end else begin
                        op_d    = (bus.rx_byte_data == CMD_RD) ? OP_RD : OP_WR;
                        state_d = GET_ADDR;
                    end
                end
            end
            GET_ADDR: begin
                if (bus.rx_byte_valid) begin
                    if (rx_bad || !addr_ok(bus.rx_byte_data, ADDR_W)) begin
                        rsp_d   = RSP_ERR;
                        state_d = TX_REQ;
                    end else begin
                        addr_d  = bus.rx_byte_data[ADDR_W-1:0];
                        state_d = (op_q == OP_RD) ? RD_WAIT : GET_DATA;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (bus.rx_byte_valid) begin
                    if (rx_bad) begin
                        rsp_d = RSP_ERR;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.rx_byte_data;
                        rsp_d     = RSP_ACK;
                    end
                    state_d = TX_REQ;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                // reg_addr has been stable for a cycle, so read data is valid now.
                rsp_d   = bus.reg_rd_data;
                state_d = TX_REQ;
            end
            TX_REQ: begin
                if (bus.rx_byte_valid) overrun_d = 1'b1;
                if (bus.tx_active)     state_d   = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.rx_byte_valid) overrun_d = 1'b1;
                if (bus.tx_done)       state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_byte_valid = (state_q == TX_REQ);
    assign bus.tx_byte_data  = rsp_q;
    assign bus.reg_addr      = addr_q;
    assign bus.reg_wr_en     = wr_en_q;
    assign bus.reg_wr_data   = wr_data_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a host-side transmitter and register model.
module tb_uart_cmd_responder;
    import uart_cmd_pkg::*;

    localparam int CLK_PER_BIT  = 10;
    localparam int ADDR_W       = 4;
    localparam int TIMEOUT_BITS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_cmd_responder_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cmd_responder #(
        .CLK_PER_BIT  (CLK_PER_BIT),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file model plus write/transmit event counters
    logic [7:0]        regs [16];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [7:0]        pre_data = 8'h00;
    int                wr_cnt = 0;
    int                tx_rises = 0;
    logic              tx_prev = 1'b0;

    assign bus.reg_rd_data = regs[bus.reg_addr];

    always @(posedge clk) begin
        if (pre_en) regs[pre_addr] <= pre_data;
        if (bus.reg_wr_en) begin
            regs[bus.reg_addr] <= bus.reg_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        tx_prev <= bus.tx_byte_valid;
        if (bus.tx_byte_valid && !tx_prev) tx_rises <= tx_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic se);
        bus.rx_byte_valid = 1'b1;
        bus.rx_byte_data  = b;
        bus.par_error     = pe;
        bus.stop_error    = se;
        tick();
        bus.rx_byte_valid = 1'b0;
        bus.par_error     = 1'b0;
        bus.stop_error    = 1'b0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    // Host transmitter: accept the byte, send for a few cycles, then report done.
    task automatic host_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!bus.tx_byte_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " tx_valid"}, bus.tx_byte_valid, 1);
        chk({tag, " tx_data"}, bus.tx_byte_data, exp);
        bus.tx_active = 1'b1;
        tick();
        chk({tag, " tx_valid drop"}, bus.tx_byte_valid, 0);
        repeat (3) tick();
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk({tag, " idle"}, bus.busy, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " tx_valid"}, bus.tx_byte_valid, 0);
        chk({tag, " tx_data"}, bus.tx_byte_data, 8'h00);
        chk({tag, " reg_addr"}, bus.reg_addr, 0);
        chk({tag, " wr_en"}, bus.reg_wr_en, 0);
        chk({tag, " wr_data"}, bus.reg_wr_data, 8'h00);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " overrun"}, bus.overrun, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte_data  = 8'h00;
        bus.par_error     = 1'b0;
        bus.stop_error    = 1'b0;
        bus.tx_active     = 1'b0;
        bus.tx_done       = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Write 0xA5 to reg 3
        w0 = wr_cnt;
        send(CMD_WR, 0, 0);
        chk("wr busy", bus.busy, 1);
        send(8'h03, 0, 0);
        send(8'hA5, 0, 0);
        chk("wr latency", bus.tx_byte_valid, 1);
        chk("wr strobe", bus.reg_wr_en, 1);
        chk("wr addr", bus.reg_addr, 3);
        chk("wr data", bus.reg_wr_data, 8'hA5);
        host_tx("wr", RSP_ACK);
        chk("wr count", wr_cnt, w0 + 1);
        chk("wr reg3", regs[3], 8'hA5);

        // Read reg 3 back, two-cycle latency
        w0 = wr_cnt;
        send(CMD_RD, 0, 0);
        send(8'h03, 0, 0);
        chk("rd wait", bus.tx_byte_valid, 0);
        tick();
        chk("rd latency", bus.tx_byte_valid, 1);
        host_tx("rd3", 8'hA5);
        chk("rd no write", wr_cnt, w0);

        // Top address 0x0F is still in range
        preload(4'hF, 8'h5A);
        send(CMD_RD, 0, 0);
        send(8'h0F, 0, 0);
        host_tx("rd15", 8'h5A);

        // Unknown command byte
        send(8'h00, 0, 0);
        chk("bad cmd latency", bus.tx_byte_valid, 1);
        host_tx("bad cmd", RSP_ERR);

        // Address 0x10 is one past the register space
        send(CMD_RD, 0, 0);
        send(8'h10, 0, 0);
        chk("bad addr latency", bus.tx_byte_valid, 1);
        host_tx("bad addr", RSP_ERR);

        // Parity error on the data byte aborts the write
        preload(4'h2, 8'h77);
        w0 = wr_cnt;
        send(CMD_WR, 0, 0);
        send(8'h02, 0, 0);
        send(8'hAA, 1, 0);
        chk("par no strobe", bus.reg_wr_en, 0);
        host_tx("par err", RSP_ERR);
        chk("par no write", wr_cnt, w0);
        chk("par reg2", regs[2], 8'h77);

        // Stop error on a valid-looking command byte
        send(CMD_WR, 0, 1);
        host_tx("stop err", RSP_ERR);

        // Byte injected during TX_WAIT sets overrun and is dropped
        send(CMD_WR, 0, 0);
        send(8'h04, 0, 0);
        send(8'h3C, 0, 0);
        bus.tx_active = 1'b1;
        tick();
        send(CMD_RD, 0, 0);
        chk("ovr flag", bus.overrun, 1);
        chk("ovr rsp", bus.tx_byte_data, RSP_ACK);
        chk("ovr busy", bus.busy, 1);
        chk("ovr tx_valid", bus.tx_byte_valid, 0);
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("ovr idle", bus.busy, 0);
        send(CMD_RD, 0, 0);
        send(8'h04, 0, 0);
        host_tx("ovr next", 8'h3C);
        chk("ovr sticky", bus.overrun, 1);

        // Reset during GET_DATA
        w0 = wr_cnt;
        send(CMD_WR, 0, 0);
        send(8'h05, 0, 0);
        rst = 1'b1;
        tick();
        chk_reset("rst getdata");
        rst = 1'b0;
        tick();
        chk("rst getdata no write", wr_cnt, w0);

        // Reset during TX_WAIT
        send(CMD_WR, 0, 0);
        send(8'h01, 0, 0);
        send(8'h11, 0, 0);
        bus.tx_active = 1'b1;
        tick();
        chk("rst txwait busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk_reset("rst txwait");
        rst = 1'b0;
        bus.tx_active = 1'b0;
        r0 = tx_rises;
        repeat (5) tick();
        chk("rst txwait no tx", tx_rises, r0);

        // Partial frame: 'W' then silence
        r0 = tx_rises;
        send(CMD_WR, 0, 0);
        repeat (205) tick();
        chk("timeout no tx", tx_rises, r0);
`ifdef UART_CMD_TIMEOUT_EN
        chk("timeout idle", bus.busy, 0);
`else
        chk("no timeout busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Write from the TX_WAIT reset test landed and is readable
        send(CMD_RD, 0, 0);
        send(8'h01, 0, 0);
        host_tx("final rd", 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
